// File: rtl/spi_rx_sequencer.sv
// SPI receive sequencer: calibrate, wait for phase lock, then deserialize MSB-first
// bytes into a valid/ready port with frame sideband and automatic stall recovery.
module spi_rx_sequencer #(
    parameter int unsigned FRAME_BYTES  = 1200,
    parameter int unsigned IDLE_TIMEOUT = 255,
    parameter int unsigned CAL_TIMEOUT  = 4095
) (
    input  logic       CLK_40,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       err_clear,
    input  logic       cal_done,
    input  logic [4:0] phase_adjust,
    input  logic       SPI_falling_edge,
    input  logic       data_in,
    output logic       phase_cal_en,
    output logic [7:0] byte_data,
    output logic       byte_sof,
    output logic       byte_eof,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_done,
    output logic       overflow,
    output logic       timeout_err,
    output logic       cal_err,
    output logic       busy
);

    localparam int unsigned IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned IT_W  = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned CT_W  = $clog2(CAL_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [IT_W-1:0]  IDLE_MAX = IT_W'(IDLE_TIMEOUT);
    localparam logic [CT_W-1:0]  CAL_MAX  = CT_W'(CAL_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_CAL, S_RECV} state_t;

    state_t           state;
    logic [4:0]       sample_cnt;
    logic             armed;
    logic [2:0]       bit_cnt;
    logic [6:0]       shreg;
    logic [IDX_W-1:0] byte_idx;
    logic [IT_W-1:0]  idle_timer;
    logic [CT_W-1:0]  cal_timer;

    logic slot_free;
    logic stalled;

    assign slot_free = !byte_valid || byte_ready;
    assign stalled   = (idle_timer == IDLE_MAX) && ((bit_cnt != '0) || (byte_idx != '0));

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            state        <= S_IDLE;
            phase_cal_en <= 1'b0;
            busy         <= 1'b0;
            sample_cnt   <= '0;
            armed        <= 1'b0;
            bit_cnt      <= '0;
            shreg        <= '0;
            byte_idx     <= '0;
            idle_timer   <= '0;
            cal_timer    <= '0;
            byte_data    <= '0;
            byte_sof     <= 1'b0;
            byte_eof     <= 1'b0;
            byte_valid   <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            timeout_err  <= 1'b0;
            cal_err      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Sticky sets later in this block override the clear.
            if (err_clear) begin
                overflow    <= 1'b0;
                timeout_err <= 1'b0;
                cal_err     <= 1'b0;
            end
            if (byte_valid && byte_ready)
                byte_valid <= 1'b0;

            if (stop) begin
                state        <= S_IDLE;
                phase_cal_en <= 1'b0;
                busy         <= 1'b0;
                armed        <= 1'b0;
                bit_cnt      <= '0;
                shreg        <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state        <= S_CAL;
                            phase_cal_en <= 1'b1;
                            busy         <= 1'b1;
                            armed        <= 1'b0;
                            bit_cnt      <= '0;
                            shreg        <= '0;
                            byte_idx     <= '0;
                            cal_timer    <= '0;
                        end
                    end
                    S_CAL: begin
                        if (cal_done) begin
                            state      <= S_RECV;
                            armed      <= 1'b0;
                            idle_timer <= '0;
                        end else if (cal_timer == CAL_MAX) begin
                            state        <= S_IDLE;
                            phase_cal_en <= 1'b0;
                            busy         <= 1'b0;
                            cal_err      <= 1'b1;
                        end else begin
                            cal_timer <= cal_timer + CT_W'(1);
                        end
                    end
                    S_RECV: begin
                        if (stalled) begin
                            state       <= S_CAL;
                            cal_timer   <= '0;
                            timeout_err <= 1'b1;
                            armed       <= 1'b0;
                            bit_cnt     <= '0;
                            shreg       <= '0;
                            byte_idx    <= '0;
                        end else if (SPI_falling_edge) begin
                            idle_timer <= '0;
                            sample_cnt <= phase_adjust;
                            armed      <= 1'b1;
                        end else begin
                            if (idle_timer != IDLE_MAX)
                                idle_timer <= idle_timer + IT_W'(1);
                            if (armed) begin
                                if (sample_cnt == '0) begin
                                    shreg   <= {shreg[5:0], data_in};
                                    armed   <= 1'b0;
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) begin
                                        // A full slot drops the byte but the frame position still advances.
                                        if (slot_free) begin
                                            byte_data  <= {shreg, data_in};
                                            byte_valid <= 1'b1;
                                            byte_sof   <= (byte_idx == '0);
                                            byte_eof   <= (byte_idx == LAST_IDX);
                                            frame_done <= (byte_idx == LAST_IDX);
                                        end else begin
                                            overflow <= 1'b1;
                                        end
                                        byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + IDX_W'(1);
                                    end
                                end else begin
                                    sample_cnt <= sample_cnt - 5'd1;
                                end
                            end
                        end
                    end
                    default: begin
                        state        <= S_IDLE;
                        phase_cal_en <= 1'b0;
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_sequencer.sv
// Self-checking bench for spi_rx_sequencer: randomized phase offsets and byte values
// checked against a frame-position model kept in the bench.
module tb_spi_rx_sequencer;

    localparam int FB = 4;
    localparam int IT = 255;
    localparam int CT = 4095;

    logic       CLK_40 = 1'b0;
    logic       reset, start, stop, err_clear, cal_done;
    logic [4:0] phase_adjust;
    logic       SPI_falling_edge, data_in, byte_ready;
    logic       phase_cal_en, byte_sof, byte_eof, byte_valid;
    logic       frame_done, overflow, timeout_err, cal_err, busy;
    logic [7:0] byte_data;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_idx = 0;
    bit ready_at_sample = 1'b0;

    always #5 CLK_40 = ~CLK_40;

    spi_rx_sequencer #(
        .FRAME_BYTES (FB),
        .IDLE_TIMEOUT(IT),
        .CAL_TIMEOUT (CT)
    ) dut (
        .CLK_40          (CLK_40),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .err_clear       (err_clear),
        .cal_done        (cal_done),
        .phase_adjust    (phase_adjust),
        .SPI_falling_edge(SPI_falling_edge),
        .data_in         (data_in),
        .phase_cal_en    (phase_cal_en),
        .byte_data       (byte_data),
        .byte_sof        (byte_sof),
        .byte_eof        (byte_eof),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .frame_done      (frame_done),
        .overflow        (overflow),
        .timeout_err     (timeout_err),
        .cal_err         (cal_err),
        .busy            (busy)
    );

    // Data_in carries the true bit only in the cycle that should be sampled
    // (edge cycle + pa + 1); returns at the negedge showing the cycle after the sample.
    task automatic send_bit(input logic b, input int pa);
        @(negedge CLK_40);
        SPI_falling_edge = 1'b1;
        phase_adjust     = pa[4:0];
        data_in          = ~b;
        for (int k = 1; k <= pa + 1; k++) begin
            @(negedge CLK_40);
            SPI_falling_edge = 1'b0;
            phase_adjust     = 5'($urandom);
            data_in          = (k == pa + 1) ? b : ~b;
            if (k == pa + 1 && ready_at_sample)
                byte_ready = 1'b1;
        end
        @(negedge CLK_40);
        data_in = ~b;
    endtask

    task automatic send_byte(input logic [7:0] v, input int pa);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], (pa < 0) ? int'($urandom_range(0, 31)) : pa);
            if (i != 0)
                repeat ($urandom_range(0, 2)) @(negedge CLK_40);
        end
    endtask

    task automatic restart();
        @(negedge CLK_40);
        stop = 1'b1;
        @(negedge CLK_40);
        stop  = 1'b0;
        start = 1'b1;
        @(negedge CLK_40);
        start = 1'b0;
        @(negedge CLK_40);
        exp_idx = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLK_40);
        n_cmp++;
        if ({phase_cal_en, byte_data, byte_sof, byte_eof, byte_valid, frame_done,
             overflow, timeout_err, cal_err, busy} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {phase_cal_en, byte_data, byte_sof, byte_eof, byte_valid, frame_done,
                      overflow, timeout_err, cal_err, busy});
        end
        reset = 1'b0;
    endtask

    task automatic test_lock_and_byte();
        @(negedge CLK_40);
        start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge CLK_40);
            SPI_falling_edge = (n == 4 || n == 6);
            data_in          = 1'($urandom);
            if (n == 5) begin
                n_cmp++;
                if ({busy, phase_cal_en} !== 2'b11) begin
                    n_bad++;
                    $display("FAIL cal_enable: got busy=%b pce=%b want 1 1", busy, phase_cal_en);
                end
            end
        end
        cal_done = 1'b1;
        @(negedge CLK_40);
        start   = 1'b0;
        exp_idx = 0;
        send_byte(8'hA5, 4);
        n_cmp++;
        if ({byte_valid, byte_data, byte_sof, byte_eof, frame_done, phase_cal_en} !== {1'b1, 8'hA5, 4'b1001}) begin
            n_bad++;
            $display("FAIL first_byte: got v=%b d=%h sof=%b eof=%b fd=%b pce=%b want 1 a5 1 0 0 1",
                     byte_valid, byte_data, byte_sof, byte_eof, frame_done, phase_cal_en);
        end
        exp_idx = (exp_idx + 1) % FB;
    endtask

    task automatic test_full_frame();
        logic [7:0] v;
        logic es, ee;
        byte_ready = 1'b1;
        restart();
        for (int n = 0; n < FB + 1; n++) begin
            v  = (n < FB) ? 8'(n + 1) : 8'($urandom);
            es = (exp_idx == 0);
            ee = (exp_idx == FB - 1);
            send_byte(v, -1);
            n_cmp++;
            if ({byte_valid, byte_data, byte_sof, byte_eof, frame_done} !== {1'b1, v, es, ee, ee}) begin
                n_bad++;
                $display("FAIL frame_byte%0d: got v=%b d=%h sof=%b eof=%b fd=%b want 1 %h %b %b %b",
                         n, byte_valid, byte_data, byte_sof, byte_eof, frame_done, v, es, ee, ee);
            end
            exp_idx = (exp_idx + 1) % FB;
            @(negedge CLK_40);
            n_cmp++;
            if ({byte_valid, frame_done} !== 2'b00) begin
                n_bad++;
                $display("FAIL frame_accept%0d: got v=%b fd=%b want 0 0", n, byte_valid, frame_done);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] x, y, z;
        logic xs, xe, zs, ze;
        x = 8'($urandom);
        y = ~x;
        z = 8'($urandom);
        @(negedge CLK_40);
        byte_ready = 1'b0;
        xs = (exp_idx == 0);
        xe = (exp_idx == FB - 1);
        send_byte(x, -1);
        exp_idx = (exp_idx + 1) % FB;
        n_cmp++;
        if ({byte_valid, byte_data, byte_sof, byte_eof, overflow} !== {1'b1, x, xs, xe, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_first: got v=%b d=%h sof=%b eof=%b ovf=%b want 1 %h %b %b 0",
                     byte_valid, byte_data, byte_sof, byte_eof, overflow, x, xs, xe);
        end
        send_byte(y, -1);
        exp_idx = (exp_idx + 1) % FB;
        n_cmp++;
        if ({byte_valid, byte_data, byte_sof, byte_eof, overflow} !== {1'b1, x, xs, xe, 1'b1}) begin
            n_bad++;
            $display("FAIL bp_hold: got v=%b d=%h sof=%b eof=%b ovf=%b want 1 %h %b %b 1",
                     byte_valid, byte_data, byte_sof, byte_eof, overflow, x, xs, xe);
        end
        byte_ready = 1'b1;
        @(negedge CLK_40);
        err_clear = 1'b1;
        @(negedge CLK_40);
        err_clear = 1'b0;
        n_cmp++;
        if ({byte_valid, overflow} !== 2'b00) begin
            n_bad++;
            $display("FAIL bp_clear: got v=%b ovf=%b want 0 0", byte_valid, overflow);
        end
        zs = (exp_idx == 0);
        ze = (exp_idx == FB - 1);
        send_byte(z, -1);
        exp_idx = (exp_idx + 1) % FB;
        n_cmp++;
        if ({byte_valid, byte_data, byte_sof, byte_eof} !== {1'b1, z, zs, ze}) begin
            n_bad++;
            $display("FAIL bp_align: got v=%b d=%h sof=%b eof=%b want 1 %h %b %b",
                     byte_valid, byte_data, byte_sof, byte_eof, z, zs, ze);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x, y;
        logic ys, ye;
        x = 8'($urandom);
        y = 8'($urandom);
        @(negedge CLK_40);
        byte_ready = 1'b0;
        send_byte(x, -1);
        exp_idx = (exp_idx + 1) % FB;
        ys = (exp_idx == 0);
        ye = (exp_idx == FB - 1);
        ready_at_sample = 1'b1;
        send_byte(y, -1);
        ready_at_sample = 1'b0;
        exp_idx = (exp_idx + 1) % FB;
        n_cmp++;
        if ({byte_valid, byte_data, byte_sof, byte_eof, overflow} !== {1'b1, y, ys, ye, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_load: got v=%b d=%h sof=%b eof=%b ovf=%b want 1 %h %b %b 0",
                     byte_valid, byte_data, byte_sof, byte_eof, overflow, y, ys, ye);
        end
        @(negedge CLK_40);
        n_cmp++;
        if (byte_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: got v=%b want 0", byte_valid);
        end
    endtask

    task automatic test_stall();
        logic [7:0] w;
        int pa;
        w = 8'($urandom);
        byte_ready = 1'b1;
        cal_done   = 1'b0;
        send_bit(1'($urandom), -0 + int'($urandom_range(0, 31)));
        send_bit(1'($urandom), int'($urandom_range(0, 31)));
        pa = int'($urandom_range(0, 31));
        @(negedge CLK_40);
        SPI_falling_edge = 1'b1;
        phase_adjust     = pa[4:0];
        for (int n = 1; n <= IT + 2; n++) begin
            @(negedge CLK_40);
            SPI_falling_edge = 1'b0;
            data_in          = 1'($urandom);
            if (n == IT + 1) begin
                n_cmp++;
                if (timeout_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_early: got terr=%b want 0", timeout_err);
                end
            end
            if (n == IT + 2) begin
                n_cmp++;
                if ({timeout_err, busy, phase_cal_en} !== 3'b111) begin
                    n_bad++;
                    $display("FAIL stall_flag: got terr=%b busy=%b pce=%b want 1 1 1",
                             timeout_err, busy, phase_cal_en);
                end
            end
        end
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK_40);
            SPI_falling_edge = (n == 1 || n == 3);
        end
        cal_done = 1'b1;
        repeat (2) @(negedge CLK_40);
        exp_idx = 0;
        send_byte(w, -1);
        exp_idx = 1;
        n_cmp++;
        if ({byte_valid, byte_data, byte_sof} !== {1'b1, w, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_resync: got v=%b d=%h sof=%b want 1 %h 1",
                     byte_valid, byte_data, byte_sof, w);
        end
    endtask

    task automatic test_cal_fail();
        @(negedge CLK_40);
        stop      = 1'b1;
        cal_done  = 1'b0;
        err_clear = 1'b1;
        @(negedge CLK_40);
        stop      = 1'b0;
        err_clear = 1'b0;
        n_cmp++;
        if ({timeout_err, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL errclr_stop: got terr=%b busy=%b want 0 0", timeout_err, busy);
        end
        start = 1'b1;
        for (int n = 1; n <= CT + 2; n++) begin
            @(negedge CLK_40);
            start = 1'b0;
            if (n == CT + 1) begin
                n_cmp++;
                if ({busy, cal_err} !== 2'b10) begin
                    n_bad++;
                    $display("FAIL calfail_early: got busy=%b cerr=%b want 1 0", busy, cal_err);
                end
            end
            if (n == CT + 2) begin
                n_cmp++;
                if ({busy, phase_cal_en, cal_err} !== 3'b001) begin
                    n_bad++;
                    $display("FAIL calfail_flag: got busy=%b pce=%b cerr=%b want 0 0 1",
                             busy, phase_cal_en, cal_err);
                end
            end
        end
        err_clear = 1'b1;
        @(negedge CLK_40);
        err_clear = 1'b0;
        n_cmp++;
        if (cal_err !== 1'b0) begin
            n_bad++;
            $display("FAIL calerr_clear: got cerr=%b want 0", cal_err);
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] v;
        v = 8'($urandom);
        cal_done = 1'b1;
        restart();
        byte_ready = 1'b0;
        send_byte(v, -1);
        @(negedge CLK_40);
        stop = 1'b1;
        @(negedge CLK_40);
        stop = 1'b0;
        n_cmp++;
        if ({byte_valid, byte_data, byte_sof, busy} !== {1'b1, v, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL stop_hold: got v=%b d=%h sof=%b busy=%b want 1 %h 1 0",
                     byte_valid, byte_data, byte_sof, busy, v);
        end
        restart();
        for (int i = 0; i < 5; i++)
            send_bit(1'($urandom), int'($urandom_range(0, 31)));
        @(negedge CLK_40);
        reset = 1'b1;
        @(negedge CLK_40);
        n_cmp++;
        if ({phase_cal_en, byte_data, byte_sof, byte_eof, byte_valid, frame_done,
             overflow, timeout_err, cal_err, busy} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got %b want all zero",
                     {phase_cal_en, byte_data, byte_sof, byte_eof, byte_valid, frame_done,
                      overflow, timeout_err, cal_err, busy});
        end
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        stop             = 1'b0;
        err_clear        = 1'b0;
        cal_done         = 1'b0;
        phase_adjust     = '0;
        SPI_falling_edge = 1'b0;
        data_in          = 1'b0;
        byte_ready       = 1'b1;
        test_reset();
        test_lock_and_byte();
        test_full_frame();
        test_backpressure();
        test_back_to_back();
        test_stall();
        test_cal_fail();
        test_reset_mid_byte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
